// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong game flow FSM: serve timing, scoring, rally count, overlay select.
module pong_game_ctrl #(
   parameter logic [3:0] WIN_SCORE   = 4'd7,
   parameter logic [6:0] SERVE_DELAY = 7'd120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       refr_tick,
   input  logic       start,
   input  logic       hit,
   input  logic       miss_l,
   input  logic       miss_r,
   output logic       graph_still,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic [7:0] rally,
   output logic [1:0] text_sel
);

   typedef enum logic [1:0] {
      ST_NEWGAME = 2'd0,
      ST_PLAY    = 2'd1,
      ST_NEWBALL = 2'd2,
      ST_OVER    = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  score_l_q, score_l_d;
   logic [3:0]  score_r_q, score_r_d;
   logic [7:0]  rally_q, rally_d;
   logic [6:0]  timer_q, timer_d;
   logic        graph_still_q, graph_still_d;
   logic [1:0]  text_sel_q, text_sel_d;
   logic        start_q;
   logic        hit_q;
   logic        start_mask_q;
   logic        start_rise;
   logic        hit_rise;

   // start_q comes out of reset low; the mask stops a button held through reset from reading as a press.
   assign start_rise = start & ~start_q & ~start_mask_q;
   assign hit_rise   = hit & ~hit_q;

   always_comb begin
      state_d   = state_q;
      score_l_d = score_l_q;
      score_r_d = score_r_q;
      rally_d   = rally_q;
      timer_d   = timer_q;

      case (state_q)
         ST_NEWGAME: begin
            if (start_rise) begin
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (miss_l && miss_r) begin
               state_d = ST_NEWBALL;
               timer_d = SERVE_DELAY;
               rally_d = 8'd0;
            end else if (miss_l) begin
               score_r_d = score_r_q + 4'd1;
               if (score_r_d == WIN_SCORE) begin
                  state_d = ST_OVER;
               end else begin
                  state_d = ST_NEWBALL;
                  timer_d = SERVE_DELAY;
                  rally_d = 8'd0;
               end
            end else if (miss_r) begin
               score_l_d = score_l_q + 4'd1;
               if (score_l_d == WIN_SCORE) begin
                  state_d = ST_OVER;
               end else begin
                  state_d = ST_NEWBALL;
                  timer_d = SERVE_DELAY;
                  rally_d = 8'd0;
               end
            end else if (hit_rise && (rally_q != 8'hFF)) begin
               rally_d = rally_q + 8'd1;
            end
         end
         ST_NEWBALL: begin
            if (refr_tick) begin
               timer_d = timer_q - 7'd1;
               if (timer_q <= 7'd1) begin
                  state_d = ST_PLAY;
                  timer_d = 7'd0;
               end
            end
         end
         ST_OVER: begin
            if (start_rise) begin
               state_d   = ST_NEWGAME;
               score_l_d = 4'd0;
               score_r_d = 4'd0;
               rally_d   = 8'd0;
            end
         end
         default: state_d = ST_NEWGAME;
      endcase

      // Outputs are decoded from the next state so they change on the same edge as the state.
      graph_still_d = (state_d != ST_PLAY);
      case (state_d)
         ST_NEWGAME: text_sel_d = 2'b01;
         ST_OVER:    text_sel_d = (score_l_d == WIN_SCORE) ? 2'b10 : 2'b11;
         default:    text_sel_d = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_NEWGAME;
         score_l_q     <= 4'd0;
         score_r_q     <= 4'd0;
         rally_q       <= 8'd0;
         timer_q       <= 7'd0;
         graph_still_q <= 1'b1;
         text_sel_q    <= 2'b01;
         start_q       <= 1'b0;
         hit_q         <= 1'b0;
         start_mask_q  <= 1'b1;
      end else begin
         state_q       <= state_d;
         score_l_q     <= score_l_d;
         score_r_q     <= score_r_d;
         rally_q       <= rally_d;
         timer_q       <= timer_d;
         graph_still_q <= graph_still_d;
         text_sel_q    <= text_sel_d;
         start_q       <= start;
         hit_q         <= hit;
         start_mask_q  <= 1'b0;
      end
   end

   assign graph_still = graph_still_q;
   assign score_l     = score_l_q;
   assign score_r     = score_r_q;
   assign rally       = rally_q;
   assign text_sel    = text_sel_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - Directed vector bench for pong_game_ctrl.
module tb_pong_game_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       refr_tick = 1'b0;
   logic       start = 1'b0;
   logic       hit = 1'b0;
   logic       miss_l = 1'b0;
   logic       miss_r = 1'b0;
   logic       graph_still;
   logic [3:0] score_l;
   logic [3:0] score_r;
   logic [7:0] rally;
   logic [1:0] text_sel;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic       r, s, h, ml, mr, t;
      logic       gs;
      logic [3:0] sl, sr;
      logic [7:0] ra;
      logic [1:0] ts;
      string      name;
   } vec_t;

   vec_t vecs[$];

   pong_game_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .refr_tick  (refr_tick),
      .start      (start),
      .hit        (hit),
      .miss_l     (miss_l),
      .miss_r     (miss_r),
      .graph_still(graph_still),
      .score_l    (score_l),
      .score_r    (score_r),
      .rally      (rally),
      .text_sel   (text_sel)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic s, input logic h,
                       input logic ml, input logic mr, input logic t);
      reset = r; start = s; hit = h; miss_l = ml; miss_r = mr; refr_tick = t;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic gs, input logic [3:0] sl,
                        input logic [3:0] sr, input logic [7:0] ra, input logic [1:0] ts);
      total++;
      if ({graph_still, score_l, score_r, rally, text_sel} !== {gs, sl, sr, ra, ts}) begin
         bad++;
         $display("FAIL %s: got gs=%0b sl=%0d sr=%0d rally=%0d ts=%b, want gs=%0b sl=%0d sr=%0d rally=%0d ts=%b",
                  name, graph_still, score_l, score_r, rally, text_sel, gs, sl, sr, ra, ts);
      end
   endtask

   task automatic addv(input string name, input logic r, input logic s, input logic h,
                       input logic ml, input logic mr, input logic t,
                       input logic gs, input logic [3:0] sl, input logic [3:0] sr,
                       input logic [7:0] ra, input logic [1:0] ts);
      vec_t v;
      v.name = name; v.r = r; v.s = s; v.h = h; v.ml = ml; v.mr = mr; v.t = t;
      v.gs = gs; v.sl = sl; v.sr = sr; v.ra = ra; v.ts = ts;
      vecs.push_back(v);
   endtask

   task automatic run_vecs();
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].r, vecs[i].s, vecs[i].h, vecs[i].ml, vecs[i].mr, vecs[i].t);
         check(vecs[i].name, vecs[i].gs, vecs[i].sl, vecs[i].sr, vecs[i].ra, vecs[i].ts);
      end
      vecs.delete();
   endtask

   // 119 ticks keep the ball parked, the 120th releases it.
   task automatic serve(input logic [3:0] sl, input logic [3:0] sr);
      for (int i = 0; i < 119; i++) step(1'b0, start, 1'b0, 1'b0, 1'b0, 1'b1);
      check("serve_wait", 1'b1, sl, sr, 8'd0, 2'b00);
      step(1'b0, start, 1'b0, 1'b0, 1'b0, 1'b1);
      check("serve_go", 1'b0, sl, sr, 8'd0, 2'b00);
   endtask

   initial begin
      //   name         r  s  h  ml mr t   gs sl sr rally ts
      addv("reset",     1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 2'b01);
      addv("newgame",   0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 2'b01);
      addv("start",     0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00);
      addv("hit1",      0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 2'b00);
      addv("hit1_lo",   0, 1, 0, 0, 0, 0,  0, 0, 0, 1, 2'b00);
      addv("hit2",      0, 1, 1, 0, 0, 0,  0, 0, 0, 2, 2'b00);
      addv("hit2_lo",   0, 1, 0, 0, 0, 0,  0, 0, 0, 2, 2'b00);
      addv("hit3",      0, 1, 1, 0, 0, 0,  0, 0, 0, 3, 2'b00);
      addv("hit3_lo",   0, 1, 0, 0, 0, 0,  0, 0, 0, 3, 2'b00);
      addv("long_hit",  0, 1, 1, 0, 0, 0,  0, 0, 0, 4, 2'b00);
      addv("long_hit",  0, 1, 1, 0, 0, 0,  0, 0, 0, 4, 2'b00);
      addv("long_hit",  0, 1, 1, 0, 0, 0,  0, 0, 0, 4, 2'b00);
      addv("long_hit",  0, 1, 1, 0, 0, 0,  0, 0, 0, 4, 2'b00);
      addv("hit_lo",    0, 1, 0, 0, 0, 0,  0, 0, 0, 4, 2'b00);
      addv("hit_missr", 0, 1, 1, 0, 1, 0,  1, 1, 0, 0, 2'b00);
      addv("newball",   0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00);
      run_vecs();
      serve(4'd1, 4'd0);

      for (int i = 0; i < 5; i++) addv("missl_held", 0, 1, 0, 1, 0, 0, 1, 1, 1, 0, 2'b00);
      addv("missl_off", 0, 1, 0, 0, 0, 0,  1, 1, 1, 0, 2'b00);
      run_vecs();
      serve(4'd1, 4'd1);

      addv("both_miss", 0, 1, 0, 1, 1, 0,  1, 1, 1, 0, 2'b00);
      addv("nb_start0", 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 2'b00);
      addv("nb_start1", 0, 1, 0, 0, 0, 0,  1, 1, 1, 0, 2'b00);
      run_vecs();
      serve(4'd1, 4'd1);

      for (int k = 2; k <= 6; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         check("score_l_up", 1'b1, 4'(k), 4'd1, 8'd0, 2'b00);
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         serve(4'(k), 4'd1);
      end

      addv("win_left",  0, 1, 0, 0, 1, 0,  1, 7, 1, 0, 2'b10);
      addv("over_miss", 0, 1, 1, 1, 0, 0,  1, 7, 1, 0, 2'b10);
      addv("over_s0",   0, 0, 0, 0, 0, 0,  1, 7, 1, 0, 2'b10);
      addv("over_s1",   0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 2'b01);
      addv("ng_s0",     0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 2'b01);
      addv("ng_s1",     0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00);
      addv("missl",     0, 1, 0, 1, 0, 0,  1, 0, 1, 0, 2'b00);
      run_vecs();

      for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("countdown50", 1'b1, 4'd0, 4'd1, 8'd0, 2'b00);

      addv("rst_mid",   1, 1, 0, 0, 0, 1,  1, 0, 0, 0, 2'b01);
      addv("rst_hold",  1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 2'b01);
      addv("rel_held",  0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 2'b01);
      addv("rel_held",  0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 2'b01);
      addv("rel_held",  0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 2'b01);
      addv("rel_s0",    0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 2'b01);
      addv("rel_s1",    0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00);
      run_vecs();

      for (int i = 0; i < 260; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      check("rally_sat", 1'b0, 4'd0, 4'd0, 8'd255, 2'b00);

      addv("miss_r_sat", 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 2'b00);
      addv("final_rst",  1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b01);
      run_vecs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
